// File: rtl/if_id_pkg.sv
// Shared definitions for the fetch/decode queue family.
//   NOP_INSTR     : canonical addi x0,x0,0 presented to decode when nothing is queued
//   payload_*     : width and bit offsets of the packed entry {pred_taken, pc, instr},
//                   expressed as functions of XLEN/ILEN so the ID/EX queue can reuse them
//   ptr_wrap_inc  : pointer increment with an explicit wrap, valid for any depth
package if_id_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Instruction sits in the low bits, PC above it, prediction bit on top.
  function automatic int payload_width(input int xlen, input int ilen);
    return xlen + ilen + 1;
  endfunction

  function automatic int payload_instr_lsb();
    return 0;
  endfunction

  function automatic int payload_pc_lsb(input int ilen);
    return ilen;
  endfunction

  function automatic int payload_pred_bit(input int xlen, input int ilen);
    return xlen + ilen;
  endfunction

  // Wrap by comparison rather than by overflow so non-power-of-2 depths work.
  function automatic int unsigned ptr_wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/pipe_queue_ctrl.sv
// Occupancy and pointer control for a small in-order pipeline queue.
// Ports:
//   clk_i, reset_i    : clock and synchronous active-high reset
//   flush_i           : drops every entry, beats any push/pop that cycle
//   in_valid_i        : producer offers an entry
//   out_ready_i       : consumer takes the head entry
//   in_ready_o        : space available, derived from registered count only
//   out_valid_o       : at least one entry held
//   push_o, pop_o     : qualified transfer strobes for the storage array
//   wr_ptr_o, rd_ptr_o: slot to write / slot at the head
//   count_o           : occupied entries
module pipe_queue_ctrl
  import if_id_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic             out_ready_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic             push_o,
  output logic             pop_o,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [CNT_W-1:0] count_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Handshake qualification; in_ready never looks at out_ready, so a full
  // queue refuses input even when the head leaves in the same cycle.
  always_comb begin
    in_ready_o  = (count_q < CNT_W'(DEPTH));
    out_valid_o = (count_q != '0);
    push_o      = in_valid_i & in_ready_o & ~flush_i;
    pop_o       = out_valid_o & out_ready_i & ~flush_i;
  end

  // Next-state: flush empties everything, otherwise pointers advance on
  // their own strobe and count moves only when exactly one side transfers.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_o) wr_ptr_d = PTR_W'(ptr_wrap_inc(32'(wr_ptr_q), DEPTH));
      if (pop_o)  rd_ptr_d = PTR_W'(ptr_wrap_inc(32'(rd_ptr_q), DEPTH));
      case ({push_o, pop_o})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: DEPTH-entry in-order buffer between fetch and decode.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset (wins over flush)
//   flush                         : redirect; drops all queued and same-cycle input
//   in_valid/in_ready             : fetch-side handshake
//   in_pc/in_instr/in_pred_taken  : fetched payload
//   out_valid/out_ready           : decode-side handshake (out_ready low = stall)
//   out_pc/out_instr/out_pred_taken : head payload, 0/NOP/0 when empty
//   count                         : occupied entries
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [ILEN-1:0]            in_instr,
  input  logic                       in_pred_taken,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [ILEN-1:0]            out_instr,
  output logic                       out_pred_taken,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW    = payload_width(XLEN, ILEN);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             push, pop;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0]    entry_q [DEPTH];
  logic [PW-1:0]    head;

  pipe_queue_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W ($clog2(DEPTH + 1))
  ) u_ctrl (
    .clk_i       (clk),
    .reset_i     (reset),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .out_ready_i (out_ready),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .push_o      (push),
    .pop_o       (pop),
    .wr_ptr_o    (wr_ptr),
    .rd_ptr_o    (rd_ptr),
    .count_o     (count)
  );

  // Payload storage carries no reset: stale slots are never visible because
  // the outputs are masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) entry_q[wr_ptr] <= {in_pred_taken, in_pc, in_instr};
  end

  // Head is read straight from storage, so data written this cycle only
  // appears next cycle; an empty queue shows a NOP with zero PC.
  always_comb begin
    head           = entry_q[rd_ptr];
    out_instr      = ILEN'(NOP_INSTR);
    out_pc         = '0;
    out_pred_taken = 1'b0;
    if (out_valid) begin
      out_instr      = head[payload_instr_lsb() +: ILEN];
      out_pc         = head[payload_pc_lsb(ILEN) +: XLEN];
      out_pred_taken = head[payload_pred_bit(XLEN, ILEN)];
    end
  end

  // The pop strobe is consumed inside the controller; kept visible here for
  // readability of the datapath.
  logic unused_pop;
  assign unused_pop = pop;

endmodule
